// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM port arbiter: port owner codes and FSM states.
package vram_arbiter_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_V    = 2'd1,
    OWNER_C    = 2'd2,
    OWNER_D    = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Level-request / ready-pulse memory handshake; the same shape serves requesters and the VRAM side.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  import vram_arbiter_pkg::*;

  logic                  request;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (output request, rw, address, wdata, input rdata, ready);
  modport slave  (input request, rw, address, wdata, output rdata, ready);

endinterface

// File: rtl/vram_arbiter_pick.sv
// Winner selection: video first unless its burst guard tripped, then C/D round-robin.
module vram_arbiter_pick
  import vram_arbiter_pkg::*;
(
  input  logic   v_request,
  input  logic   c_request,
  input  logic   d_request,
  input  owner_t rr_last,
  input  logic   burst_sat,
  output owner_t winner
);

  always_comb begin
    winner = OWNER_NONE;
    if (v_request && (!burst_sat || !(c_request || d_request))) begin
      winner = OWNER_V;
    end else if (rr_last == OWNER_C) begin
      if (d_request)      winner = OWNER_D;
      else if (c_request) winner = OWNER_C;
    end else begin
      if (c_request)      winner = OWNER_C;
      else if (d_request) winner = OWNER_D;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one VRAM port between video (V), CPU (C) and DMA (D); all memory-side outputs registered.
//   state   | meaning
//   IDLE    | no access outstanding, arbitrate pending requests
//   ACCESS  | o_mem_* held for the owner until memory signals ready
//   RELEASE | owner answered, waiting for memory ready to fall
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int VIDEO_BURST_MAX = 8,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic           i_clock,
  input  logic           i_reset,
  vram_arbiter_if.slave  v_bus,
  vram_arbiter_if.slave  c_bus,
  vram_arbiter_if.slave  d_bus,
  vram_arbiter_if.master mem_bus,
  output owner_t         o_grant
);

  localparam int BURST_W = $clog2(VIDEO_BURST_MAX + 1);

  state_t                state_q;
  state_t                state_next;
  owner_t                winner;
  owner_t                rr_last;
  logic [BURST_W-1:0]    burst_cnt;
  logic                  burst_sat;
  logic                  cd_pending;
  logic                  grant_now;
  logic                  complete;
  logic                  sel_rw;
  logic [ADDR_WIDTH-1:0] sel_address;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign burst_sat  = (burst_cnt >= BURST_W'(VIDEO_BURST_MAX));
  assign cd_pending = c_bus.request | d_bus.request;

  vram_arbiter_pick u_pick (
    .v_request (v_bus.request),
    .c_request (c_bus.request),
    .d_request (d_bus.request),
    .rr_last   (rr_last),
    .burst_sat (burst_sat),
    .winner    (winner)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    grant_now  = 1'b0;
    complete   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (winner != OWNER_NONE) begin
          state_next = ST_ACCESS;
          grant_now  = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (mem_bus.ready) begin
          state_next = ST_RELEASE;
          complete   = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!mem_bus.ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_rw      = v_bus.rw;
    sel_address = v_bus.address;
    sel_wdata   = v_bus.wdata;
    case (winner)
      OWNER_C: begin
        sel_rw      = c_bus.rw;
        sel_address = c_bus.address;
        sel_wdata   = c_bus.wdata;
      end
      OWNER_D: begin
        sel_rw      = d_bus.rw;
        sel_address = d_bus.address;
        sel_wdata   = d_bus.wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      mem_bus.request <= 1'b0;
      mem_bus.rw      <= 1'b0;
      mem_bus.address <= '0;
      mem_bus.wdata   <= '0;
      v_bus.rdata     <= '0;
      c_bus.rdata     <= '0;
      d_bus.rdata     <= '0;
      v_bus.ready     <= 1'b0;
      c_bus.ready     <= 1'b0;
      d_bus.ready     <= 1'b0;
      o_grant         <= OWNER_NONE;
      rr_last         <= OWNER_D;
      burst_cnt       <= '0;
    end else begin
      v_bus.ready <= 1'b0;
      c_bus.ready <= 1'b0;
      d_bus.ready <= 1'b0;

      if (grant_now) begin
        mem_bus.request <= 1'b1;
        mem_bus.rw      <= sel_rw;
        mem_bus.address <= sel_address;
        mem_bus.wdata   <= sel_wdata;
        o_grant         <= winner;
        if (winner == OWNER_V) begin
          // The guard only counts video grants that actually made C/D wait.
          if (!cd_pending)     burst_cnt <= '0;
          else if (!burst_sat) burst_cnt <= burst_cnt + BURST_W'(1);
        end else begin
          burst_cnt <= '0;
          rr_last   <= winner;
        end
      end

      if (complete) begin
        mem_bus.request <= 1'b0;
        o_grant         <= OWNER_NONE;
        case (o_grant)
          OWNER_V: begin
            v_bus.rdata <= mem_bus.rdata;
            v_bus.ready <= 1'b1;
          end
          OWNER_C: begin
            c_bus.rdata <= mem_bus.rdata;
            c_bus.ready <= 1'b1;
          end
          OWNER_D: begin
            d_bus.rdata <= mem_bus.rdata;
            d_bus.ready <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: requester agents, a VRAM model and an in-order service scoreboard.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int AW    = 32;
  localparam int BURST = 8;

  typedef struct {
    owner_t      who;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic   i_clock = 1'b0;
  logic   i_reset = 1'b1;
  owner_t o_grant;

  vram_arbiter_if #(.ADDR_WIDTH(AW)) v_if ();
  vram_arbiter_if #(.ADDR_WIDTH(AW)) c_if ();
  vram_arbiter_if #(.ADDR_WIDTH(AW)) d_if ();
  vram_arbiter_if #(.ADDR_WIDTH(AW)) m_if ();

  vram_arbiter #(.VIDEO_BURST_MAX(BURST), .ADDR_WIDTH(AW)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .v_bus   (v_if),
    .c_bus   (c_if),
    .d_bus   (d_if),
    .mem_bus (m_if),
    .o_grant (o_grant)
  );

  always #5 i_clock = ~i_clock;

  int          checks = 0;
  int          errors = 0;
  txn_t        sb_q[$];
  txn_t        pv_q[$];
  txn_t        pc_q[$];
  txn_t        pd_q[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] last_rdata [3];
  int          mem_lat   = 2;
  int          mem_hold  = 0;
  int          lat_cnt   = 0;
  int          hold_cnt  = 0;
  int          ready_low = 16;
  logic        mready    = 1'b0;
  logic        prev_req  = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic txn_t mk(owner_t who, logic rw, logic [31:0] addr, logic [31:0] wdata);
    txn_t t;
    t.who   = who;
    t.rw    = rw;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = model_rd(addr);
    return t;
  endfunction

  function automatic logic [31:0] port_rdata(int p);
    case (p)
      0:       return v_if.rdata;
      1:       return c_if.rdata;
      default: return d_if.rdata;
    endcase
  endfunction

  task automatic issue(txn_t t);
    case (t.who)
      OWNER_V: pv_q.push_back(t);
      OWNER_C: pc_q.push_back(t);
      default: pd_q.push_back(t);
    endcase
  endtask

  task automatic cycle();
    logic [2:0] rdy;
    txn_t       t;
    @(negedge i_clock);
    rdy = {d_if.ready, c_if.ready, v_if.ready};

    if (m_if.request) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL unexpected_grant got=%0d exp=none", o_grant);
      end else begin
        chk("grant_owner", o_grant, sb_q[0].who);
        chk("mem_rw", m_if.rw, sb_q[0].rw);
        chk("mem_addr", m_if.address, sb_q[0].addr);
        if (sb_q[0].rw) chk("mem_wdata", m_if.wdata, sb_q[0].wdata);
        if (!prev_req) chk("release_gap", ready_low >= 2, 1);
      end
    end else if (mready) begin
      chk("release_grant", o_grant, OWNER_NONE);
    end

    for (int p = 0; p < 3; p++) begin
      if (rdy[p]) begin
        chk("one_ready", $countones(rdy), 1);
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL unexpected_ready got=port%0d exp=none", p);
        end else begin
          t = sb_q.pop_front();
          chk("ready_owner", p + 1, t.who);
          chk("rdata", port_rdata(p), t.rdata);
          for (int q = 0; q < 3; q++)
            if (q != p) chk("rdata_hold", port_rdata(q), last_rdata[q]);
          last_rdata[p] = t.rdata;
        end
      end
    end

    if (mready) begin
      if (!m_if.request) begin
        if (hold_cnt == 0) mready = 1'b0;
        else hold_cnt--;
      end
    end else if (m_if.request) begin
      if (lat_cnt + 1 >= mem_lat) begin
        mready     = 1'b1;
        m_if.rdata = model_rd(m_if.address);
        if (m_if.rw) mem_model[m_if.address] = m_if.wdata;
        hold_cnt   = mem_hold;
        lat_cnt    = 0;
      end else begin
        lat_cnt++;
      end
    end
    m_if.ready = mready;
    ready_low  = mready ? 0 : ready_low + 1;
    prev_req   = m_if.request;

    if (v_if.request && v_if.ready) v_if.request = 1'b0;
    else if (!v_if.request && pv_q.size() > 0) begin
      t = pv_q.pop_front();
      v_if.rw = t.rw; v_if.address = t.addr; v_if.wdata = t.wdata; v_if.request = 1'b1;
    end
    if (c_if.request && c_if.ready) c_if.request = 1'b0;
    else if (!c_if.request && pc_q.size() > 0) begin
      t = pc_q.pop_front();
      c_if.rw = t.rw; c_if.address = t.addr; c_if.wdata = t.wdata; c_if.request = 1'b1;
    end
    if (d_if.request && d_if.ready) d_if.request = 1'b0;
    else if (!d_if.request && pd_q.size() > 0) begin
      t = pd_q.pop_front();
      d_if.rw = t.rw; d_if.address = t.addr; d_if.wdata = t.wdata; d_if.request = 1'b1;
    end
  endtask

  task automatic run_until_done(int max_cycles);
    int n = 0;
    while ((sb_q.size() > 0 || pv_q.size() > 0 || pc_q.size() > 0 || pd_q.size() > 0 ||
            v_if.request || c_if.request || d_if.request) && n < max_cycles) begin
      cycle();
      n++;
    end
    chk("timeout", n < max_cycles, 1);
    repeat (4) cycle();
  endtask

  task automatic clear_tb_side();
    sb_q.delete(); pv_q.delete(); pc_q.delete(); pd_q.delete();
    v_if.request = 1'b0; c_if.request = 1'b0; d_if.request = 1'b0;
    mready = 1'b0; m_if.ready = 1'b0; m_if.rdata = '0;
    lat_cnt = 0; hold_cnt = 0; prev_req = 1'b0;
    for (int p = 0; p < 3; p++) last_rdata[p] = '0;
  endtask

  initial begin
    txn_t t;
    int   n;
    v_if.rw = 0; v_if.address = '0; v_if.wdata = '0;
    c_if.rw = 0; c_if.address = '0; c_if.wdata = '0;
    d_if.rw = 0; d_if.address = '0; d_if.wdata = '0;
    clear_tb_side();
    mem_model[32'h4000] = 32'h1234_5678;

    // Reset values
    repeat (2) @(negedge i_clock);
    chk("rst_grant", o_grant, OWNER_NONE);
    chk("rst_mem_req", m_if.request, 0);
    chk("rst_mem_addr", m_if.address, 0);
    chk("rst_mem_wdata", m_if.wdata, 0);
    chk("rst_readys", {v_if.ready, c_if.ready, d_if.ready}, 0);
    chk("rst_rdata_c", c_if.rdata, 0);
    chk("rst_rr_last", dut.rr_last, OWNER_D);
    chk("rst_burst", dut.burst_cnt, 0);
    i_reset = 1'b0;

    // C and D contend: round-robin starting with C
    for (int i = 0; i < 3; i++) begin
      t = mk(OWNER_C, 1'b0, 32'h1000 + 32'(i * 4), '0); issue(t); sb_q.push_back(t);
    end
    for (int i = 0; i < 3; i++) begin
      t = mk(OWNER_D, 1'b0, 32'h2000 + 32'(i * 4), '0);
      issue(t);
    end
    sb_q.delete();
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(mk(OWNER_C, 1'b0, 32'h1000 + 32'(i * 4), '0));
      sb_q.push_back(mk(OWNER_D, 1'b0, 32'h2000 + 32'(i * 4), '0));
    end
    run_until_done(200);

    // Single C write
    t = mk(OWNER_C, 1'b1, 32'h100, 32'hDEAD_BEEF); issue(t); sb_q.push_back(t);
    run_until_done(50);

    // V beats a simultaneous C
    t = mk(OWNER_V, 1'b0, 32'h4000, '0); issue(t); sb_q.push_back(t);
    t = mk(OWNER_C, 1'b0, 32'h200, '0);  issue(t); sb_q.push_back(t);
    run_until_done(80);
    chk("v_rdata_4000", v_if.rdata, 32'h1234_5678);

    // Video burst guard: 8 V grants, one forced C grant, V resumes
    for (int i = 0; i < 10; i++) issue(mk(OWNER_V, 1'b0, 32'h8000 + 32'(i * 4), '0));
    issue(mk(OWNER_C, 1'b0, 32'h300, '0));
    for (int i = 0; i < 8; i++) sb_q.push_back(mk(OWNER_V, 1'b0, 32'h8000 + 32'(i * 4), '0));
    sb_q.push_back(mk(OWNER_C, 1'b0, 32'h300, '0));
    for (int i = 8; i < 10; i++) sb_q.push_back(mk(OWNER_V, 1'b0, 32'h8000 + 32'(i * 4), '0));
    n = 0;
    while (sb_q.size() > 3 && n < 300) begin cycle(); n++; end
    chk("burst_saturated", dut.burst_cnt, BURST);
    while (sb_q.size() > 2 && n < 300) begin cycle(); n++; end
    chk("burst_after_c", dut.burst_cnt, 0);
    run_until_done(100);

    // Memory ready lingers 3 cycles: no regrant until it falls
    mem_hold = 3;
    t = mk(OWNER_D, 1'b0, 32'h500, '0); issue(t); sb_q.push_back(t);
    t = mk(OWNER_C, 1'b0, 32'h600, '0); issue(t); sb_q.push_back(t);
    run_until_done(100);
    mem_hold = 0;

    // Reset in the middle of an access
    issue(mk(OWNER_C, 1'b0, 32'h700, '0)); sb_q.push_back(mk(OWNER_C, 1'b0, 32'h700, '0));
    n = 0;
    while (!m_if.request && n < 50) begin cycle(); n++; end
    chk("mid_access_started", m_if.request, 1);
    #1 i_reset = 1'b1;
    #1;
    chk("async_mem_req", m_if.request, 0);
    chk("async_readys", {v_if.ready, c_if.ready, d_if.ready}, 0);
    chk("async_grant", o_grant, OWNER_NONE);
    clear_tb_side();
    @(negedge i_clock);
    i_reset = 1'b0;
    t = mk(OWNER_C, 1'b0, 32'h740, '0); issue(t); sb_q.push_back(t);
    run_until_done(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
